mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-master arbiter in front of a single-cycle memory port.
//   Master 0 is the CPU, master 1 is the debug/DMA port.
//
//   Ports
//     clk_i, rst_i              clock, synchronous active-high reset
//     mN_req_i/we_i/lock_i      request, write enable, lock hint for master N
//     mN_addr_i/wdata_i/funct3_i transfer attributes for master N
//     mN_gnt_o                  combinational grant (accepted = req & gnt)
//     mN_rvalid_o/rdata_o       read response, exactly one cycle after accept
//     mem_*_o                   memory command, zero when nothing is accepted
//     mem_rdata_i               memory read data, valid one cycle after read
//
//   Build option
//     MEMARB_ROUND_ROBIN_EN     when defined, an IDLE conflict goes to the
//                               master not granted last; otherwise master 0.
//
//   A locked owner keeps the port for up to MAX_LOCK consecutive transfers.
//   A forced release hands the next conflict to the other master.
module mem_port_arbiter #(
    parameter int BITNESS  = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               m0_req_i,
    input  logic               m0_we_i,
    input  logic               m0_lock_i,
    input  logic [BITNESS-1:0] m0_addr_i,
    input  logic [BITNESS-1:0] m0_wdata_i,
    input  logic [2:0]         m0_funct3_i,
    output logic               m0_gnt_o,
    output logic               m0_rvalid_o,
    output logic [BITNESS-1:0] m0_rdata_o,

    input  logic               m1_req_i,
    input  logic               m1_we_i,
    input  logic               m1_lock_i,
    input  logic [BITNESS-1:0] m1_addr_i,
    input  logic [BITNESS-1:0] m1_wdata_i,
    input  logic [2:0]         m1_funct3_i,
    output logic               m1_gnt_o,
    output logic               m1_rvalid_o,
    output logic [BITNESS-1:0] m1_rdata_o,

    output logic [BITNESS-1:0] mem_addr_o,
    output logic [BITNESS-1:0] mem_wdata_o,
    output logic               mem_we_o,
    output logic               mem_re_o,
    output logic [2:0]         mem_funct3_o,
    input  logic [BITNESS-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam int            CW      = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

    state_t        state;
    logic [CW-1:0] lock_cnt;
    logic          last_gnt;
    logic          pref_vld;   // one-shot preference after a forced release
    logic          pref_own;
    logic          rv_vld;     // read outstanding, answered this cycle
    logic          rv_own;

    logic          rr_win1;
    logic          win1;
    logic          accept;
    logic          sel;
    logic          acc_we;
    logic          acc_lock;
    logic [CW-1:0] cnt_nxt;

`ifdef MEMARB_ROUND_ROBIN_EN
    assign rr_win1 = ~last_gnt;
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
    assign rr_win1 = 1'b0;
`endif

    assign win1 = pref_vld ? pref_own : rr_win1;

    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (!rst_i) begin
            case (state)
                LOCK0: m0_gnt_o = m0_req_i;
                LOCK1: m1_gnt_o = m1_req_i;
                default: begin
                    if (m0_req_i && m1_req_i) begin
                        m1_gnt_o = win1;
                        m0_gnt_o = ~win1;
                    end else begin
                        m0_gnt_o = m0_req_i;
                        m1_gnt_o = m1_req_i;
                    end
                end
            endcase
        end
    end

    // Grants already imply the request, so accept is just "any grant".
    assign accept   = m0_gnt_o | m1_gnt_o;
    assign sel      = m1_gnt_o;
    assign acc_we   = sel ? m1_we_i   : m0_we_i;
    assign acc_lock = sel ? m1_lock_i : m0_lock_i;
    // The counter is zero in IDLE, so this also yields 1 for the entering transfer.
    assign cnt_nxt  = lock_cnt + 1'b1;

    always_comb begin
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_funct3_o = '0;
        mem_we_o     = 1'b0;
        mem_re_o     = 1'b0;
        if (m0_gnt_o) begin
            mem_addr_o   = m0_addr_i;
            mem_wdata_o  = m0_wdata_i;
            mem_funct3_o = m0_funct3_i;
            mem_we_o     = m0_we_i;
            mem_re_o     = ~m0_we_i;
        end else if (m1_gnt_o) begin
            mem_addr_o   = m1_addr_i;
            mem_wdata_o  = m1_wdata_i;
            mem_funct3_o = m1_funct3_i;
            mem_we_o     = m1_we_i;
            mem_re_o     = ~m1_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            lock_cnt <= '0;
            last_gnt <= 1'b1;
            pref_vld <= 1'b0;
            pref_own <= 1'b0;
            rv_vld   <= 1'b0;
            rv_own   <= 1'b0;
        end else begin
            rv_vld <= accept & ~acc_we;
            rv_own <= sel;
            if (accept)
                last_gnt <= sel;
            // Preference only lives for the first IDLE cycle after release.
            if (state == IDLE)
                pref_vld <= 1'b0;
            // In a lock state only the owner can be granted.
            if (accept && acc_lock) begin
                if (cnt_nxt >= MAX_CNT) begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                    pref_vld <= 1'b1;
                    pref_own <= ~sel;
                end else begin
                    state    <= sel ? LOCK1 : LOCK0;
                    lock_cnt <= cnt_nxt;
                end
            end else if (state != IDLE) begin
                state    <= IDLE;
                lock_cnt <= '0;
            end
        end
    end

    // Gating with rst_i drops a response whose read preceded a reset.
    assign m0_rvalid_o = rv_vld & ~rv_own & ~rst_i;
    assign m1_rvalid_o = rv_vld &  rv_own & ~rst_i;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int BW = 32;
    localparam int ML = 4;
`ifdef MEMARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          m0_req_i, m0_we_i, m0_lock_i, m0_gnt_o, m0_rvalid_o;
    logic [BW-1:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic [2:0]    m0_funct3_i;
    logic          m1_req_i, m1_we_i, m1_lock_i, m1_gnt_o, m1_rvalid_o;
    logic [BW-1:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [2:0]    m1_funct3_i;
    logic [BW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic          mem_we_o, mem_re_o;
    logic [2:0]    mem_funct3_o;

    mem_port_arbiter #(.BITNESS(BW), .MAX_LOCK(ML)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_funct3_i(m0_funct3_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_funct3_i(m1_funct3_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_re_o(mem_re_o), .mem_funct3_o(mem_funct3_o), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        bit            rst;
        bit [1:0]      req, we, lk;
        bit [BW-1:0]   addr [2];
        bit [BW-1:0]   wd [2];
        bit [2:0]      f3 [2];
        bit [BW-1:0]   rdata;
    } stim_t;

    typedef struct {
        bit [1:0]    gnt;
        bit          we, re;
        bit [BW-1:0] addr, wdata;
        bit [2:0]    f3;
        bit [1:0]    rv;
        bit [BW-1:0] rd [2];
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference view: who owns a lock (-1 none), how long the current run is,
    // who was served last, who is owed the next conflict, who awaits a reply.
    int owner = -1, run = 0, last = 1, pref = -1, pend = -1;

    function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        int   g;
        @(posedge clk);
        #1;
        rst_i       = s.rst;
        m0_req_i    = s.req[0];  m1_req_i    = s.req[1];
        m0_we_i     = s.we[0];   m1_we_i     = s.we[1];
        m0_lock_i   = s.lk[0];   m1_lock_i   = s.lk[1];
        m0_addr_i   = s.addr[0]; m1_addr_i   = s.addr[1];
        m0_wdata_i  = s.wd[0];   m1_wdata_i  = s.wd[1];
        m0_funct3_i = s.f3[0];   m1_funct3_i = s.f3[1];
        mem_rdata_i = s.rdata;

        if (s.rst)                 g = -1;
        else if (owner >= 0)       g = s.req[owner] ? owner : -1;
        else if (s.req == 2'b11)   g = (pref >= 0) ? pref : (RR ? 1 - last : 0);
        else if (s.req[0])         g = 0;
        else if (s.req[1])         g = 1;
        else                       g = -1;

        e = '{gnt: 2'b00, we: 1'b0, re: 1'b0, addr: '0, wdata: '0, f3: '0,
              rv: 2'b00, rd: '{default: '0}};
        if (g >= 0) begin
            e.gnt[g] = 1'b1;
            e.we     = s.we[g];
            e.re     = !s.we[g];
            e.addr   = s.addr[g];
            e.wdata  = s.wd[g];
            e.f3     = s.f3[g];
        end
        if (!s.rst && pend >= 0) begin
            e.rv[pend] = 1'b1;
            e.rd[pend] = s.rdata;
        end
        sb.push_back(e);

        if (s.rst) begin
            owner = -1; run = 0; last = 1; pref = -1; pend = -1;
        end else begin
            pend = (g >= 0 && !s.we[g]) ? g : -1;
            if (g >= 0) last = g;
            if (owner < 0) pref = -1;
            if (g >= 0 && s.lk[g]) begin
                run++;
                if (run >= ML) begin
                    owner = -1; run = 0; pref = 1 - g;
                end else begin
                    owner = g;
                end
            end else begin
                owner = -1; run = 0;
            end
        end
    endtask

    function automatic stim_t mk(bit r0, bit w0, bit l0, bit [BW-1:0] a0, bit [BW-1:0] d0,
                                 bit r1, bit w1, bit l1, bit [BW-1:0] a1, bit [BW-1:0] d1,
                                 bit [BW-1:0] rdata);
        stim_t s;
        s.rst = 1'b0;
        s.req = {r1, r0}; s.we = {w1, w0}; s.lk = {l1, l0};
        s.addr[0] = a0; s.addr[1] = a1;
        s.wd[0] = d0;   s.wd[1] = d1;
        s.f3[0] = 3'd2; s.f3[1] = 3'd5;
        s.rdata = rdata;
        return s;
    endfunction

    function automatic stim_t rnd(int rst_pct);
        stim_t s;
        s.rst = ($urandom_range(99) < rst_pct);
        for (int i = 0; i < 2; i++) begin
            s.req[i]  = ($urandom_range(9) < 7);
            s.we[i]   = $urandom_range(1);
            s.lk[i]   = ($urandom_range(9) < 5);
            s.addr[i] = $urandom;
            s.wd[i]   = $urandom;
            s.f3[i]   = 3'($urandom_range(7));
        end
        s.rdata = $urandom;
        return s;
    endfunction

    task automatic do_reset(int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rnd(0);
            s.rst = 1'b1;
            apply(s);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("m0_gnt",    BW'(m0_gnt_o),     BW'(e.gnt[0]));
            chk("m1_gnt",    BW'(m1_gnt_o),     BW'(e.gnt[1]));
            chk("mem_we",    BW'(mem_we_o),     BW'(e.we));
            chk("mem_re",    BW'(mem_re_o),     BW'(e.re));
            chk("mem_addr",  mem_addr_o,        e.addr);
            chk("mem_wdata", mem_wdata_o,       e.wdata);
            chk("mem_f3",    BW'(mem_funct3_o), BW'(e.f3));
            chk("m0_rvalid", BW'(m0_rvalid_o),  BW'(e.rv[0]));
            chk("m1_rvalid", BW'(m1_rvalid_o),  BW'(e.rv[1]));
            chk("m0_rdata",  m0_rdata_o,        e.rd[0]);
            chk("m1_rdata",  m1_rdata_o,        e.rd[1]);
        end
    end

    initial begin
        rst_i = 1'b1;
        m0_req_i = 0; m0_we_i = 0; m0_lock_i = 0; m0_addr_i = '0; m0_wdata_i = '0; m0_funct3_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_lock_i = 0; m1_addr_i = '0; m1_wdata_i = '0; m1_funct3_i = '0;
        mem_rdata_i = '0;

        // Reset with random requests: grants must stay low.
        do_reset(3);

        // Single read by m0, data arrives the following cycle.
        apply(mk(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'h0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678));

        // Four-cycle conflict without lock.
        do_reset(1);
        for (int i = 0; i < 4; i++)
            apply(mk(1, 0, 0, 32'h100 + i, 0, 1, 0, 0, 32'h200 + i, 0, 32'hC0 + i));

        // m1 locks alone, then m0 contends: forced release after MAX_LOCK.
        do_reset(1);
        apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h300, 32'h1, 0));
        for (int i = 0; i < ML + 1; i++)
            apply(mk(1, 1, 0, 32'h40, 32'h2, 1, 1, 1, 32'h304 + 4 * i, 32'h1 + i, 0));

        // m0 writes 0xA5 to 0x20 while m1 reads.
        do_reset(1);
        apply(mk(1, 1, 0, 32'h20, 32'hA5, 1, 0, 0, 32'h50, 0, 32'h0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h50, 0, 32'hAAAA5555));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555AAAA));

        // Reset right after a locked read: reply dropped, conflict goes to m0.
        do_reset(1);
        apply(mk(1, 0, 1, 32'h60, 0, 0, 0, 0, 0, 0, 0));
        do_reset(1);
        apply(mk(1, 0, 0, 32'h64, 0, 1, 0, 0, 32'h68, 0, 32'hFEED));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBEEF));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            apply(rnd(1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1));

        repeat (2) @(negedge clk);
        chk("sb_drained", BW'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
